pong_graph: RTL

- Pixel-generation stage directly downstream of vga_sync in the pong design.
- Consumes pixel_x, pixel_y, video_on and p_tick; holds the game objects (left wall, right paddle, ball); advances them once per frame; drives the registered 12-bit RGB to the VGA pins.
- Contains the game-state FSM and the paddle-hit counter.

---
 rtl/pong_pkg.sv | 29 ++
 rtl/pong_ball.sv | 42 ++++
 rtl/pong_graph.sv | 86 ++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared geometry, colours and game-state encoding for the pong pixel generator.
package pong_pkg;
    localparam logic [9:0] H_VIS       = 10'd640;
    localparam logic [9:0] V_VIS       = 10'd480;
    localparam logic [9:0] REFR_Y      = V_VIS + 10'd1;
    localparam logic [9:0] WALL_X_L    = 10'd32;
    localparam logic [9:0] WALL_X_R    = 10'd35;
    localparam logic [9:0] PAD_X_L     = 10'd600;
    localparam logic [9:0] PAD_X_R     = 10'd603;
    localparam logic [9:0] PAD_H       = 10'd72;
    localparam logic [9:0] PAD_LAST    = PAD_H - 10'd1;
    localparam logic [9:0] PAD_V       = 10'd4;
    localparam logic [9:0] BALL_SIZE   = 10'd8;
    localparam logic [9:0] BALL_LAST   = BALL_SIZE - 10'd1;
    localparam logic [9:0] BALL_V      = 10'd2;
    localparam logic [9:0] PAD_Y_INIT  = 10'd204;
    localparam logic [9:0] BALL_X_INIT = 10'd316;
    localparam logic [9:0] BALL_Y_INIT = 10'd236;
    localparam int         MISS_FRAMES = 60;
    localparam logic [11:0] COL_BG    = 12'hFFF;
    localparam logic [11:0] COL_WALL  = 12'h00F;
    localparam logic [11:0] COL_PAD   = 12'h0F0;
    localparam logic [11:0] COL_BALL  = 12'hF00;
    localparam logic [11:0] COL_BLANK = 12'h000;
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, MISS = 2'd2} state_t;
    function automatic logic in_range(input logic [9:0] v, input logic [9:0] lo, input logic [9:0] hi);
        return v >= lo && v <= hi;
    endfunction
endpackage

// File: rtl/pong_ball.sv
// pong_ball: ball position, velocity and wall/paddle/miss collision detection, stepped once per frame.
module pong_ball
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       refr_tick_i,
    input  state_t     state_i,
    input  logic [9:0] pad_y_i,
    output logic [9:0] ball_x_o,
    output logic [9:0] ball_y_o,
    output logic       hit_o,
    output logic       miss_o
);
    localparam logic [9:0] V_POS = BALL_V;
    localparam logic [9:0] V_NEG = -BALL_V;
    logic [9:0] x_q, y_q, dx_q, dy_q, dx_d, dy_d, x_r, y_b;
    assign x_r = x_q + BALL_LAST;
    assign y_b = y_q + BALL_LAST;
    always_comb begin
        miss_o = x_r >= H_VIS - 10'd1;
        hit_o  = !miss_o && in_range(x_r, PAD_X_L, PAD_X_R) && y_b >= pad_y_i && y_q <= pad_y_i + PAD_LAST;
        dx_d   = x_q <= WALL_X_R ? V_POS : hit_o ? V_NEG : dx_q;
        dy_d   = y_q <= BALL_V ? V_POS : y_b >= V_VIS - 10'd1 - BALL_V ? V_NEG : dy_q;
    end
    // Position moves with the velocity held before this frame's bounce decisions.
    always_ff @(posedge clk) begin
        if (!reset || (refr_tick_i && state_i == IDLE)) begin
            x_q  <= BALL_X_INIT;
            y_q  <= BALL_Y_INIT;
            dx_q <= V_NEG;
            dy_q <= V_POS;
        end else if (refr_tick_i && state_i == PLAY) begin
            x_q  <= x_q + dx_q;
            y_q  <= y_q + dy_q;
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end
    assign ball_x_o = x_q;
    assign ball_y_o = y_q;
endmodule

// File: rtl/pong_graph.sv
// pong_graph: pong object rendering, paddle control, game FSM and hit counter downstream of vga_sync.
module pong_graph
    import pong_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic [1:0]  btn,
    input  logic        start,
    output logic [11:0] rgb,
    output logic [7:0]  hit_cnt,
    output logic        miss
);
    localparam int MW = $clog2(MISS_FRAMES);
    localparam logic [MW-1:0] MCNT_LAST = MW'(MISS_FRAMES - 1);
    state_t          state_q;
    logic [9:0]      pad_q, ball_x, ball_y;
    logic [MW-1:0]   mcnt_q;
    logic [7:0]      hit_q;
    logic            miss_q, refr_tick, ball_hit, ball_miss, wall_on, pad_on, ball_on;
    logic [11:0]     rgb_q, col_d;
    assign refr_tick = p_tick && pixel_x == 10'd0 && pixel_y == REFR_Y;
    pong_ball u_ball (
        .clk        (clk),
        .reset      (reset),
        .refr_tick_i(refr_tick),
        .state_i    (state_q),
        .pad_y_i    (pad_q),
        .ball_x_o   (ball_x),
        .ball_y_o   (ball_y),
        .hit_o      (ball_hit),
        .miss_o     (ball_miss)
    );
    always_ff @(posedge clk) begin
        if (!reset)
            pad_q <= PAD_Y_INIT;
        else if (refr_tick && btn == 2'b10 && pad_q + PAD_LAST < V_VIS - 10'd1 - PAD_V)
            pad_q <= pad_q + PAD_V;
        else if (refr_tick && btn == 2'b01 && pad_q > PAD_V)
            pad_q <= pad_q - PAD_V;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            hit_q   <= '0;
            miss_q  <= 1'b0;
            mcnt_q  <= '0;
        end else begin
            miss_q <= refr_tick && state_q == PLAY && ball_miss;
            if (refr_tick)
                case (state_q)
                    IDLE: if (start) begin
                        state_q <= PLAY;
                        hit_q   <= '0;
                    end
                    PLAY: if (ball_miss) begin
                        state_q <= MISS;
                        mcnt_q  <= '0;
                    end else if (ball_hit && hit_q != 8'hFF)
                        hit_q <= hit_q + 1'b1;
                    MISS: if (mcnt_q == MCNT_LAST) state_q <= IDLE;
                          else mcnt_q <= mcnt_q + 1'b1;
                    default: state_q <= IDLE;
                endcase
        end
    end
    always_comb begin
        wall_on = in_range(pixel_x, WALL_X_L, WALL_X_R);
        pad_on  = in_range(pixel_x, PAD_X_L, PAD_X_R) && in_range(pixel_y, pad_q, pad_q + PAD_LAST);
        ball_on = state_q == PLAY && in_range(pixel_x, ball_x, ball_x + BALL_LAST)
                  && in_range(pixel_y, ball_y, ball_y + BALL_LAST);
        col_d   = !video_on ? COL_BLANK : wall_on ? COL_WALL : pad_on ? COL_PAD : ball_on ? COL_BALL : COL_BG;
    end
    always_ff @(posedge clk) begin
        if (!reset)
            rgb_q <= COL_BLANK;
        else if (p_tick)
            rgb_q <= col_d;
    end
    assign rgb     = rgb_q;
    assign hit_cnt = hit_q;
    assign miss    = miss_q;
endmodule
